pl_perf_counter_bank: RTL and testbench

Synthesizable performance-monitor block for the pipelined CPU. It is the hardware successor of the simulation-only cycle, stall and branch-prediction tallies. It holds NUM_CH independent event counters plus a run-cycle counter, with start/halt/timeout control, per-channel overflow flags, a snapshot bank and a registered readout port. It sits beside the CPU top and is fed single-cycle event strobes (stall, branch predicted, branch mispredicted, etc.).

---
 rtl/pl_perf_pkg.sv | 16 +
 rtl/pl_perf_counter.sv | 56 +++++
 rtl/pl_perf_counter_bank.sv | 155 +++++++++++++++
 tb/tb_pl_perf_counter_bank.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pl_perf_pkg.sv
// Shared encodings for the performance-monitor counter bank.
package pl_perf_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_HALTED  = 2'b10,
      ST_TIMEOUT = 2'b11
   } state_e;

   localparam int unsigned MODE_WRAP = 0;
   localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/pl_perf_counter.sv
// One event counter: clear, increment enable, wrap or saturate, sticky overflow flag.
module pl_perf_counter
   import pl_perf_pkg::*;
#(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned SAT_MODE = MODE_WRAP
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] cnt_nxt_c,
   output logic             ovf_nxt_c
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             at_max;

   // Next value: clear wins, otherwise increment with wrap/saturate at all-ones.
   always_comb begin
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      at_max = &cnt_q;
      if (clr_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc_i) begin
         if (at_max) begin
            ovf_d = 1'b1;
            cnt_d = (SAT_MODE == MODE_SAT) ? cnt_q : '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign ovf_o     = ovf_q;
   assign cnt_nxt_c = cnt_d;
   assign ovf_nxt_c = ovf_d;

endmodule

// File: rtl/pl_perf_counter_bank.sv
// Performance-monitor bank: NUM_CH event counters plus a run-cycle counter,
// run control with halt/timeout, snapshot bank and registered readout.
// The cycle counter is selectable only when SEL_W can encode NUM_CH.
module pl_perf_counter_bank
   import pl_perf_pkg::*;
#(
   parameter int unsigned NUM_CH     = 8,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned SAT_MODE   = MODE_WRAP,
   parameter int unsigned MAX_CYCLES = 200000,
   parameter int unsigned SEL_W      = 3
) (
   input  logic              input_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hlt,
   input  logic [NUM_CH-1:0] event_vec,
   input  logic              snap,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_ovf,
   output logic [CNT_W-1:0]  cycles_consumed,
   output logic [1:0]        state,
   output logic              done,
   output logic              timeout
);

   localparam int unsigned      NUM_CNT  = NUM_CH + 1;
   localparam int unsigned      CYC_IDX  = NUM_CH;
   localparam bit               TMO_EN   = (MAX_CYCLES != 0);
   localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(MAX_CYCLES - 1) : '0;

   state_e           state_q, state_d;
   logic             done_q, done_d;
   logic             tmo_q, tmo_d;

   logic [CNT_W-1:0] cnt_q    [NUM_CNT];
   logic [CNT_W-1:0] cnt_nxt  [NUM_CNT];
   logic             ovf_q    [NUM_CNT];
   logic             ovf_nxt  [NUM_CNT];
   logic [CNT_W-1:0] snap_cnt_q [NUM_CNT];
   logic             snap_ovf_q [NUM_CNT];
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_ovf_q, rd_ovf_d;

   logic [NUM_CNT-1:0] inc;
   logic               run, clr, tmo_hit, exit_run;

   assign run      = (state_q == ST_RUN);
   assign clr      = start & ~run;
   assign tmo_hit  = TMO_EN && (cnt_q[CYC_IDX] == TMO_LAST);
   assign exit_run = run & (hlt | tmo_hit);

   // Event channels count their strobe; the last counter counts every RUN cycle.
   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      if (g < NUM_CH) begin : g_ev
         assign inc[g] = run & event_vec[g];
      end else begin : g_cyc
         assign inc[g] = run;
      end
      pl_perf_counter #(
         .CNT_W    (CNT_W),
         .SAT_MODE (SAT_MODE)
      ) u_cnt (
         .clk_i     (input_clk),
         .rst_i     (rst),
         .clr_i     (clr),
         .inc_i     (inc[g]),
         .cnt_o     (cnt_q[g]),
         .ovf_o     (ovf_q[g]),
         .cnt_nxt_c (cnt_nxt[g]),
         .ovf_nxt_c (ovf_nxt[g])
      );
   end

   // State register with registered status flags.
   always_ff @(posedge input_clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state logic; halt takes priority over timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (start) state_d = ST_RUN;
         ST_RUN: begin
            if (hlt)          state_d = ST_HALTED;
            else if (tmo_hit) state_d = ST_TIMEOUT;
         end
         ST_HALTED,
         ST_TIMEOUT: if (start) state_d = ST_RUN;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Status flags decoded from the next state so they line up with state_q.
   always_comb begin
      done_d = 1'b0;
      tmo_d  = 1'b0;
      if (state_d == ST_HALTED || state_d == ST_TIMEOUT) done_d = 1'b1;
      if (state_d == ST_TIMEOUT)                         tmo_d  = 1'b1;
   end

   // Readout mux over the snapshot bank; out-of-range selects read zero.
   always_comb begin
      rd_data_d = '0;
      rd_ovf_d  = 1'b0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
         if (32'(rd_sel) == i) begin
            rd_data_d = snap_cnt_q[i];
            rd_ovf_d  = snap_ovf_q[i];
         end
      end
   end

   // Snapshot bank: run exit captures post-increment values, else snap captures live values.
   always_ff @(posedge input_clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CNT; i++) begin
            snap_cnt_q[i] <= '0;
            snap_ovf_q[i] <= 1'b0;
         end
         rd_data_q <= '0;
         rd_ovf_q  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (exit_run) begin
               snap_cnt_q[i] <= cnt_nxt[i];
               snap_ovf_q[i] <= ovf_nxt[i];
            end else if (snap) begin
               snap_cnt_q[i] <= cnt_q[i];
               snap_ovf_q[i] <= ovf_q[i];
            end
         end
         rd_data_q <= rd_data_d;
         rd_ovf_q  <= rd_ovf_d;
      end
   end

   assign rd_data         = rd_data_q;
   assign rd_ovf          = rd_ovf_q;
   assign cycles_consumed = cnt_q[CYC_IDX];
   assign state           = state_q;
   assign done            = done_q;
   assign timeout         = tmo_q;

endmodule

// File: tb/tb_pl_perf_counter_bank.sv
// Directed bench for pl_perf_counter_bank: three configurations share one stimulus
// (a: wrap/no timeout, b: saturate/no timeout, c: wrap/MAX_CYCLES=16).
module tb_pl_perf_counter_bank;

   logic       clk = 1'b0;
   logic       rst, start, hlt, snap;
   logic [3:0] ev;
   logic [2:0] rd_sel;

   logic [7:0] a_rd, a_cyc, b_rd, b_cyc, c_rd, c_cyc;
   logic       a_ovf, a_done, a_tmo, b_ovf, b_done, b_tmo, c_ovf, c_done, c_tmo;
   logic [1:0] a_st, b_st, c_st;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int         dut;
      string      tag;
      logic [7:0] d;
      logic       o;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   pl_perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(0), .MAX_CYCLES(0), .SEL_W(3)) dut_a (
      .input_clk(clk), .rst(rst), .start(start), .hlt(hlt), .event_vec(ev), .snap(snap),
      .rd_sel(rd_sel), .rd_data(a_rd), .rd_ovf(a_ovf), .cycles_consumed(a_cyc),
      .state(a_st), .done(a_done), .timeout(a_tmo));

   pl_perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1), .MAX_CYCLES(0), .SEL_W(3)) dut_b (
      .input_clk(clk), .rst(rst), .start(start), .hlt(hlt), .event_vec(ev), .snap(snap),
      .rd_sel(rd_sel), .rd_data(b_rd), .rd_ovf(b_ovf), .cycles_consumed(b_cyc),
      .state(b_st), .done(b_done), .timeout(b_tmo));

   pl_perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(0), .MAX_CYCLES(16), .SEL_W(3)) dut_c (
      .input_clk(clk), .rst(rst), .start(start), .hlt(hlt), .event_vec(ev), .snap(snap),
      .rd_sel(rd_sel), .rd_data(c_rd), .rd_ovf(c_ovf), .cycles_consumed(c_cyc),
      .state(c_st), .done(c_done), .timeout(c_tmo));

   // One clock; inputs are driven and outputs sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int dut, input string tag, input logic [7:0] d, input logic o);
      exp_t e;
      e.dut = dut; e.tag = tag; e.d = d; e.o = o;
      sb.push_back(e);
   endtask

   // Select a readout channel, wait for the registered result, drain the scoreboard.
   task automatic rd_req(input logic [2:0] sel);
      exp_t       e;
      logic [7:0] od;
      logic       oo;
      rd_sel = sel;
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.dut)
            0:       begin od = a_rd; oo = a_ovf; end
            1:       begin od = b_rd; oo = b_ovf; end
            default: begin od = c_rd; oo = c_ovf; end
         endcase
         chk({e.tag, "_data"}, od, e.d);
         chk({e.tag, "_ovf"}, 8'(oo), 8'(e.o));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; hlt = 1'b0; snap = 1'b0; ev = 4'b0; rd_sel = 3'd0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_state", 8'(a_st), 8'd0);
      chk("rst_cyc", a_cyc, 8'd0);
      chk("rst_done", 8'(a_done), 8'd0);
      chk("rst_tmo", 8'(c_tmo), 8'd0);
      chk("rst_rd", a_rd, 8'd0);
      chk("rst_rdovf", 8'(a_ovf), 8'd0);

      // 1: ten events on channel 0, halt on the tenth cycle
      start = 1'b1; tick(); start = 1'b0;
      ev = 4'b0001;
      repeat (9) tick();
      hlt = 1'b1; tick(); hlt = 1'b0; ev = 4'b0;
      chk("t1_state", 8'(a_st), 8'd2);
      chk("t1_done", 8'(a_done), 8'd1);
      chk("t1_tmo", 8'(a_tmo), 8'd0);
      chk("t1_cyc", a_cyc, 8'd10);
      push_exp(0, "t1_ch0", 8'd10, 1'b0); rd_req(3'd0);
      push_exp(0, "t1_cyc_snap", 8'd10, 1'b0); rd_req(3'd4);
      push_exp(0, "t1_sel5", 8'd0, 1'b0); rd_req(3'd5);

      // 2/3: 260 events on channel 1 -> wrap to 4, or saturate at 255
      start = 1'b1; tick(); start = 1'b0;
      ev = 4'b0010;
      repeat (259) tick();
      hlt = 1'b1; tick(); hlt = 1'b0; ev = 4'b0;
      chk("t2_cyc_wrap", a_cyc, 8'd4);
      chk("t3_cyc_sat", b_cyc, 8'd255);
      push_exp(0, "t2_ch1", 8'd4, 1'b1);
      push_exp(1, "t3_ch1", 8'd255, 1'b1);
      rd_req(3'd1);
      push_exp(0, "t2_ch0", 8'd0, 1'b0);
      push_exp(1, "t3_ch0", 8'd0, 1'b0);
      rd_req(3'd0);
      push_exp(0, "t2_cycsnap", 8'd4, 1'b1);
      rd_req(3'd4);

      // 4: timeout after 16 cycles with all channels active, then frozen
      start = 1'b1; tick(); start = 1'b0;
      ev = 4'b1111;
      repeat (16) tick();
      chk("t4_state", 8'(c_st), 8'd3);
      chk("t4_tmo", 8'(c_tmo), 8'd1);
      chk("t4_done", 8'(c_done), 8'd1);
      chk("t4_cyc", c_cyc, 8'd16);
      for (int i = 0; i < 5; i++) begin
         push_exp(2, $sformatf("t4_ch%0d", i), 8'd16, 1'b0);
         rd_req(3'(i));
      end
      repeat (20) tick();
      chk("t4_frz_state", 8'(c_st), 8'd3);
      chk("t4_frz_cyc", c_cyc, 8'd16);
      push_exp(2, "t4_frz_ch3", 8'd16, 1'b0); rd_req(3'd3);

      // 4b: halt on the timeout cycle wins
      start = 1'b1; tick(); start = 1'b0;
      repeat (15) tick();
      hlt = 1'b1; tick(); hlt = 1'b0; ev = 4'b0;
      chk("t4b_state", 8'(c_st), 8'd2);
      chk("t4b_tmo", 8'(c_tmo), 8'd0);
      chk("t4b_cyc", c_cyc, 8'd16);
      push_exp(2, "t4b_ch0", 8'd16, 1'b0); rd_req(3'd0);

      // 5: manual snap mid-run, then halt with a coincident snap
      start = 1'b1; tick(); start = 1'b0;
      ev = 4'b0100;
      repeat (5) tick();
      snap = 1'b1; tick(); snap = 1'b0;
      push_exp(0, "t5_snap_ch2", 8'd5, 1'b0); rd_req(3'd2);
      chk("t5_live_cyc", a_cyc, 8'd7);
      chk("t5_live_state", 8'(a_st), 8'd1);
      push_exp(0, "t5_snap_cyc", 8'd5, 1'b0); rd_req(3'd4);
      repeat (3) tick();
      hlt = 1'b1; snap = 1'b1; tick(); hlt = 1'b0; snap = 1'b0; ev = 4'b0;
      chk("t5_cyc", a_cyc, 8'd12);
      push_exp(0, "t5_auto_ch2", 8'd12, 1'b0); rd_req(3'd2);
      push_exp(0, "t5_auto_cyc", 8'd12, 1'b0); rd_req(3'd4);

      // 6: reset mid-run, IDLE ignores hlt/events, then a fresh run
      start = 1'b1; tick(); start = 1'b0;
      ev = 4'b0001;
      repeat (6) tick();
      rst = 1'b1; tick(); rst = 1'b0; ev = 4'b0;
      chk("t6_state", 8'(a_st), 8'd0);
      chk("t6_cyc", a_cyc, 8'd0);
      chk("t6_done", 8'(a_done), 8'd0);
      chk("t6_rd", a_rd, 8'd0);
      hlt = 1'b1; ev = 4'b0001; tick(); hlt = 1'b0; ev = 4'b0;
      chk("t6_idle_state", 8'(a_st), 8'd0);
      chk("t6_idle_cyc", a_cyc, 8'd0);
      push_exp(0, "t6_old_ch0", 8'd0, 1'b0); rd_req(3'd0);
      push_exp(0, "t6_old_cyc", 8'd0, 1'b0); rd_req(3'd4);
      start = 1'b1; tick(); start = 1'b0;
      ev = 4'b0001;
      repeat (2) tick();
      hlt = 1'b1; tick(); hlt = 1'b0; ev = 4'b0;
      chk("t6_new_state", 8'(a_st), 8'd2);
      chk("t6_new_cyc", a_cyc, 8'd3);
      push_exp(0, "t6_new_ch0", 8'd3, 1'b0); rd_req(3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
